// File: rtl/piece_controller.sv
// Falling-piece controller: spawns a tetromino, applies gravity, moves and
// clockwise rotation against a board occupancy vector, then hands the four
// final cell coordinates to board memory through a lock handshake.
`timescale 1ns/1ps
module piece_controller #(
    parameter int COLS        = 10,
    parameter int ROWS        = 20,
    parameter int GRAV_PERIOD = 30,
    parameter int SOFT_PERIOD = 2,
    parameter int XW          = $clog2(COLS),
    parameter int YW          = $clog2(ROWS + 2)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 spawn_req,
    input  logic [2:0]           spawn_shape,
    input  logic                 move_left,
    input  logic                 move_right,
    input  logic                 rotate_cw,
    input  logic                 soft_drop,
    input  logic [ROWS*COLS-1:0] board_occ,
    input  logic                 lock_ack,
    output logic [4*XW-1:0]      cell_x,
    output logic [4*YW-1:0]      cell_y,
    output logic                 active,
    output logic                 lock_valid,
    output logic                 game_over,
    output logic [1:0]           orient
);
    // Signed width wide enough for both coordinates plus a step either way.
    localparam int SW = ((XW > YW) ? XW : YW) + 2;
    localparam int GW = (GRAV_PERIOD > 1) ? $clog2(GRAV_PERIOD) : 1;
    localparam int IW = $clog2(ROWS * COLS);

    localparam logic [XW-1:0]        SPAWN_X = XW'(COLS / 2 - 1);
    localparam logic [YW-1:0]        SPAWN_Y = YW'(ROWS - 2);
    localparam logic signed [SW-1:0] COLS_S  = SW'(COLS);
    localparam logic signed [SW-1:0] ROWS_S  = SW'(ROWS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SPAWN = 3'd1,
        S_FALL  = 3'd2,
        S_LOCK  = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    // One offset packed as {dx[2:0], dy[2:0]}, both two's complement.
    function automatic logic [5:0] pack_off(input logic signed [2:0] dx, input logic signed [2:0] dy);
        return {dx, dy};
    endfunction

    // Orient-0 offsets of all four cells, cell 0 in the low six bits.
    function automatic logic [23:0] shape_table(input logic [2:0] shape);
        logic [23:0] t;
        case (shape)
            3'd1:    t = {pack_off(3'sd1, 3'sd1), pack_off(3'sd0, 3'sd1), pack_off(3'sd1, 3'sd0), pack_off(3'sd0, 3'sd0)};
            3'd2:    t = {pack_off(3'sd0, 3'sd1), pack_off(3'sd1, 3'sd0), pack_off(3'sd0, 3'sd0), pack_off(-3'sd1, 3'sd0)};
            3'd3:    t = {pack_off(3'sd1, 3'sd0), pack_off(3'sd0, 3'sd0), pack_off(-3'sd1, 3'sd0), pack_off(-3'sd1, 3'sd1)};
            3'd4:    t = {pack_off(3'sd1, 3'sd1), pack_off(3'sd1, 3'sd0), pack_off(3'sd0, 3'sd0), pack_off(-3'sd1, 3'sd0)};
            3'd5:    t = {pack_off(3'sd1, 3'sd1), pack_off(3'sd0, 3'sd1), pack_off(3'sd0, 3'sd0), pack_off(-3'sd1, 3'sd0)};
            3'd6:    t = {pack_off(3'sd1, 3'sd0), pack_off(3'sd0, 3'sd0), pack_off(3'sd0, 3'sd1), pack_off(-3'sd1, 3'sd1)};
            default: t = {pack_off(3'sd2, 3'sd0), pack_off(3'sd1, 3'sd0), pack_off(3'sd0, 3'sd0), pack_off(-3'sd1, 3'sd0)};
        endcase
        return t;
    endfunction

    // Each clockwise quarter turn maps (dx,dy) to (dy,-dx).
    function automatic logic [5:0] rot_offset(input logic [5:0] o, input logic [1:0] r);
        logic signed [2:0] dx;
        logic signed [2:0] dy;
        logic [5:0]        res;
        dx = o[5:3];
        dy = o[2:0];
        case (r)
            2'd0:    res = {dx, dy};
            2'd1:    res = {dy, -dx};
            2'd2:    res = {-dx, -dy};
            default: res = {-dy, dx};
        endcase
        return res;
    endfunction

    state_t                 state_q, state_d;
    logic [2:0]             shape_q, shape_d;
    logic [1:0]             orient_q, orient_d;
    logic [XW-1:0]          px_q, px_d;
    logic [YW-1:0]          py_q, py_d;
    logic [GW-1:0]          grav_q, grav_d;
    logic [4*XW-1:0]        cell_x_q, cell_x_d;
    logic [4*YW-1:0]        cell_y_q, cell_y_d;
    logic                   active_q, lock_valid_q, game_over_q;

    logic [2:0]             cand_shape_s;
    logic [1:0]             cand_or_s;
    logic signed [SW-1:0]   cand_px_s, cand_py_s;
    logic [23:0]            tbl_s;
    logic [5:0]             off_s [4];
    logic signed [SW-1:0]   cx_s [4];
    logic signed [SW-1:0]   cy_s [4];
    logic [IW-1:0]          idx_s [4];
    logic [3:0]             blk_s;
    logic [4*XW-1:0]        cand_cx_s;
    logic [4*YW-1:0]        cand_cy_s;
    logic                   cand_blocked_s;
    logic [GW-1:0]          grav_lim_s;
    logic                   grav_due_s;
    logic                   load_s;

    // Gravity becomes due when the counter reaches the active period minus one.
    always_comb begin
        grav_lim_s = soft_drop ? GW'(SOFT_PERIOD - 1) : GW'(GRAV_PERIOD - 1);
        grav_due_s = (grav_q >= grav_lim_s);
    end

    // Pick the single pose this cycle may move to (spawn, drop, rotate or shift).
    always_comb begin
        cand_shape_s = shape_q;
        cand_or_s    = orient_q;
        cand_px_s    = $signed({{(SW-XW){1'b0}}, px_q});
        cand_py_s    = $signed({{(SW-YW){1'b0}}, py_q});
        case (state_q)
            S_IDLE: begin
                cand_shape_s = (spawn_shape == 3'd7) ? 3'd0 : spawn_shape;
                cand_or_s    = 2'd0;
                cand_px_s    = $signed({{(SW-XW){1'b0}}, SPAWN_X});
                cand_py_s    = $signed({{(SW-YW){1'b0}}, SPAWN_Y});
            end
            S_FALL: begin
                if (grav_due_s) begin
                    cand_py_s = $signed({{(SW-YW){1'b0}}, py_q}) - SW'(1);
                end else if (rotate_cw) begin
                    // The O piece is rotation-symmetric and never changes orient.
                    cand_or_s = (shape_q == 3'd1) ? orient_q : orient_q + 2'd1;
                end else if (move_left && !move_right) begin
                    cand_px_s = $signed({{(SW-XW){1'b0}}, px_q}) - SW'(1);
                end else if (move_right && !move_left) begin
                    cand_px_s = $signed({{(SW-XW){1'b0}}, px_q}) + SW'(1);
                end else begin
                    cand_or_s = orient_q;
                end
            end
            default: cand_shape_s = shape_q;
        endcase
    end

    // Candidate cell coordinates and their collision against walls, floor and board.
    always_comb begin
        tbl_s     = shape_table(cand_shape_s);
        cand_cx_s = '0;
        cand_cy_s = '0;
        for (int k = 0; k < 4; k++) begin
            off_s[k] = rot_offset(tbl_s[k*6 +: 6], cand_or_s);
            cx_s[k]  = cand_px_s + $signed({{(SW-3){off_s[k][5]}}, off_s[k][5:3]});
            cy_s[k]  = cand_py_s + $signed({{(SW-3){off_s[k][2]}}, off_s[k][2:0]});
            idx_s[k] = IW'(int'(cy_s[k]) * COLS + int'(cx_s[k]));
            // Rows at or above ROWS are open sky and never collide.
            blk_s[k] = cx_s[k][SW-1] | (cx_s[k] >= COLS_S) | cy_s[k][SW-1]
                     | ((cy_s[k] < ROWS_S) & board_occ[idx_s[k]]);
            cand_cx_s[k*XW +: XW] = cx_s[k][XW-1:0];
            cand_cy_s[k*YW +: YW] = cy_s[k][YW-1:0];
        end
        cand_blocked_s = |blk_s;
    end

    // Next-state, pose and counter logic.
    always_comb begin
        state_d  = state_q;
        shape_d  = shape_q;
        orient_d = orient_q;
        px_d     = px_q;
        py_d     = py_q;
        grav_d   = grav_q;
        cell_x_d = cell_x_q;
        cell_y_d = cell_y_q;
        load_s   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (spawn_req) begin
                    load_s  = 1'b1;
                    state_d = S_SPAWN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SPAWN: begin
                grav_d = '0;
                if (cand_blocked_s) begin
                    state_d = S_OVER;
                end else begin
                    state_d = S_FALL;
                end
            end
            S_FALL: begin
                if (tick) begin
                    if (grav_due_s) begin
                        grav_d = '0;
                        if (cand_blocked_s) begin
                            state_d = S_LOCK;
                        end else begin
                            load_s = 1'b1;
                        end
                    end else begin
                        grav_d = grav_q + GW'(1);
                        load_s = !cand_blocked_s;
                    end
                end else begin
                    grav_d = grav_q;
                end
            end
            S_LOCK: begin
                if (lock_ack) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_LOCK;
                end
            end
            S_OVER:  state_d = S_OVER;
            default: state_d = S_IDLE;
        endcase
        if (load_s) begin
            shape_d  = cand_shape_s;
            orient_d = cand_or_s;
            px_d     = cand_px_s[XW-1:0];
            py_d     = cand_py_s[YW-1:0];
            cell_x_d = cand_cx_s;
            cell_y_d = cand_cy_s;
        end else begin
            shape_d  = shape_q;
        end
    end

    // State, pose and registered outputs; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            shape_q      <= 3'd0;
            orient_q     <= 2'd0;
            px_q         <= '0;
            py_q         <= '0;
            grav_q       <= '0;
            cell_x_q     <= '0;
            cell_y_q     <= '0;
            active_q     <= 1'b0;
            lock_valid_q <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            shape_q      <= shape_d;
            orient_q     <= orient_d;
            px_q         <= px_d;
            py_q         <= py_d;
            grav_q       <= grav_d;
            cell_x_q     <= cell_x_d;
            cell_y_q     <= cell_y_d;
            active_q     <= (state_d == S_FALL);
            lock_valid_q <= (state_d == S_LOCK);
            game_over_q  <= (state_d == S_OVER);
        end
    end

    assign cell_x     = cell_x_q;
    assign cell_y     = cell_y_q;
    assign active     = active_q;
    assign lock_valid = lock_valid_q;
    assign game_over  = game_over_q;
    assign orient     = orient_q;
endmodule

// File: tb/tb_piece_controller.sv
// Bench for piece_controller: directed steps followed by random stimulus,
// every cycle compared with a pose-level reference model of the game rules.
`timescale 1ns/1ps
module tb_piece_controller;
    localparam int COLS = 10;
    localparam int ROWS = 20;
    localparam int GP   = 30;
    localparam int SP   = 2;
    localparam int XW   = $clog2(COLS);
    localparam int YW   = $clog2(ROWS + 2);

    localparam int M_IDLE  = 0;
    localparam int M_SPAWN = 1;
    localparam int M_FALL  = 2;
    localparam int M_LOCK  = 3;
    localparam int M_OVER  = 4;

    logic                 clk = 1'b0;
    logic                 reset, tick, spawn_req, move_left, move_right, rotate_cw, soft_drop, lock_ack;
    logic [2:0]           spawn_shape;
    logic [ROWS*COLS-1:0] board;
    logic [4*XW-1:0]      cell_x;
    logic [4*YW-1:0]      cell_y;
    logic                 active, lock_valid, game_over;
    logic [1:0]           orient;

    int total = 0;
    int bad   = 0;

    // Orient-0 offsets: I O T J L S Z
    int DX [7][4] = '{'{-1,0,1,2}, '{0,1,0,1}, '{-1,0,1,0}, '{-1,-1,0,1}, '{-1,0,1,1}, '{-1,0,0,1}, '{-1,0,0,1}};
    int DY [7][4] = '{'{0,0,0,0},  '{0,0,1,1}, '{0,0,0,1},  '{1,0,0,0},   '{0,0,0,1},  '{0,0,1,1},  '{1,1,0,0}};

    int m_mode, m_shape, m_px, m_py, m_or, m_cnt;
    int m_cx [4];
    int m_cy [4];

    always #5 clk = ~clk;

    piece_controller #(.COLS(COLS), .ROWS(ROWS), .GRAV_PERIOD(GP), .SOFT_PERIOD(SP)) dut (
        .clk(clk), .reset(reset), .tick(tick), .spawn_req(spawn_req), .spawn_shape(spawn_shape),
        .move_left(move_left), .move_right(move_right), .rotate_cw(rotate_cw), .soft_drop(soft_drop),
        .board_occ(board), .lock_ack(lock_ack), .cell_x(cell_x), .cell_y(cell_y), .active(active),
        .lock_valid(lock_valid), .game_over(game_over), .orient(orient)
    );

    function automatic void cell_off(input int sh, input int k, input int o, output int dx, output int dy);
        int t;
        dx = DX[sh][k];
        dy = DY[sh][k];
        for (int r = 0; r < o; r++) begin
            t  = dx;
            dx = dy;
            dy = -t;
        end
    endfunction

    function automatic bit pose_free(input int sh, input int px, input int py, input int o);
        int dx, dy, x, y;
        for (int k = 0; k < 4; k++) begin
            cell_off(sh, k, o, dx, dy);
            x = px + dx;
            y = py + dy;
            if (x < 0 || x >= COLS || y < 0) return 1'b0;
            if (y < ROWS && board[y*COLS + x]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic set_pose(input int sh, input int px, input int py, input int o);
        int dx, dy;
        m_shape = sh; m_px = px; m_py = py; m_or = o;
        for (int k = 0; k < 4; k++) begin
            cell_off(sh, k, o, dx, dy);
            m_cx[k] = px + dx;
            m_cy[k] = py + dy;
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        int per;
        if (reset) begin
            m_mode = M_IDLE; m_cnt = 0; m_shape = 0; m_px = 0; m_py = 0; m_or = 0;
            for (int k = 0; k < 4; k++) begin m_cx[k] = 0; m_cy[k] = 0; end
        end else begin
            case (m_mode)
                M_IDLE: if (spawn_req) begin
                    set_pose((int'(spawn_shape) == 7) ? 0 : int'(spawn_shape), COLS/2 - 1, ROWS - 2, 0);
                    m_mode = M_SPAWN;
                end
                M_SPAWN: begin
                    if (pose_free(m_shape, m_px, m_py, m_or)) begin m_mode = M_FALL; m_cnt = 0; end
                    else m_mode = M_OVER;
                end
                M_FALL: if (tick) begin
                    per = soft_drop ? SP : GP;
                    if (m_cnt >= per - 1) begin
                        m_cnt = 0;
                        if (pose_free(m_shape, m_px, m_py - 1, m_or)) set_pose(m_shape, m_px, m_py - 1, m_or);
                        else m_mode = M_LOCK;
                    end else begin
                        m_cnt++;
                        if (rotate_cw) begin
                            if (m_shape != 1 && pose_free(m_shape, m_px, m_py, (m_or + 1) % 4))
                                set_pose(m_shape, m_px, m_py, (m_or + 1) % 4);
                        end else if (move_left && !move_right) begin
                            if (pose_free(m_shape, m_px - 1, m_py, m_or)) set_pose(m_shape, m_px - 1, m_py, m_or);
                        end else if (move_right && !move_left) begin
                            if (pose_free(m_shape, m_px + 1, m_py, m_or)) set_pose(m_shape, m_px + 1, m_py, m_or);
                        end
                    end
                end
                M_LOCK: if (lock_ack) m_mode = M_IDLE;
                default: ;
            endcase
        end
    endtask

    function automatic int gx(input int k);
        return int'(cell_x[k*XW +: XW]);
    endfunction

    function automatic int gy(input int k);
        return int'(cell_y[k*YW +: YW]);
    endfunction

    task automatic check_outputs(input string tag);
        logic [4*XW-1:0] ex;
        logic [4*YW-1:0] ey;
        for (int k = 0; k < 4; k++) begin
            ex[k*XW +: XW] = XW'(m_cx[k]);
            ey[k*YW +: YW] = YW'(m_cy[k]);
        end
        total++; assert (cell_x === ex) else begin bad++; $error("FAIL %s cell_x got=%h exp=%h", tag, cell_x, ex); end
        total++; assert (cell_y === ey) else begin bad++; $error("FAIL %s cell_y got=%h exp=%h", tag, cell_y, ey); end
        total++; assert (active === (m_mode == M_FALL)) else begin bad++; $error("FAIL %s active got=%b exp=%0d", tag, active, m_mode == M_FALL); end
        total++; assert (lock_valid === (m_mode == M_LOCK)) else begin bad++; $error("FAIL %s lock_valid got=%b exp=%0d", tag, lock_valid, m_mode == M_LOCK); end
        total++; assert (game_over === (m_mode == M_OVER)) else begin bad++; $error("FAIL %s game_over got=%b exp=%0d", tag, game_over, m_mode == M_OVER); end
        total++; assert (orient === 2'(m_or)) else begin bad++; $error("FAIL %s orient got=%0d exp=%0d", tag, orient, m_or); end
    endtask

    task automatic check_const(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin bad++; $error("FAIL %s got=%0d exp=%0d", tag, got, exp); end
    endtask

    task automatic cyc(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic clear_inputs();
        tick = 1'b0; spawn_req = 1'b0; spawn_shape = 3'd0; move_left = 1'b0; move_right = 1'b0;
        rotate_cw = 1'b0; soft_drop = 1'b0; lock_ack = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1; cyc("reset");
        reset = 1'b0;
    endtask

    task automatic spawn(input logic [2:0] sh);
        spawn_req = 1'b1; spawn_shape = sh; cyc("spawn_req");
        spawn_req = 1'b0; cyc("spawn_chk");
    endtask

    task automatic new_board();
        board = '0;
        for (int y = 0; y < 6; y++)
            for (int x = 0; x < COLS; x++)
                board[y*COLS + x] = ($urandom_range(0, 99) < 35);
        if ($urandom_range(0, 9) == 0)
            board[$urandom_range(ROWS-2, ROWS-1)*COLS + $urandom_range(0, COLS-1)] = 1'b1;
    endtask

    initial begin
        int n;
        board = '0;
        clear_inputs();
        reset = 1'b1; cyc("reset0"); cyc("reset1");
        check_const("rst_cells_x", int'(cell_x), 0);
        check_const("rst_active", int'(active), 0);
        reset = 1'b0;

        // T spawn pose and gravity timing
        spawn(3'd2);
        check_const("t_active", int'(active), 1);
        check_const("t_c0", gx(0)*100 + gy(0), 318);
        check_const("t_c1", gx(1)*100 + gy(1), 418);
        check_const("t_c2", gx(2)*100 + gy(2), 518);
        check_const("t_c3", gx(3)*100 + gy(3), 419);
        check_const("t_orient", int'(orient), 0);
        tick = 1'b1;
        for (int i = 0; i < 29; i++) cyc("grav_wait");
        check_const("grav_29", gy(1), 18);
        cyc("grav_30");
        check_const("grav_30", gy(1), 17);
        soft_drop = 1'b1;
        for (int i = 0; i < 4; i++) cyc("soft");
        check_const("soft_4", gy(1), 15);

        // I piece against the left wall, then conflicting moves
        do_reset();
        spawn(3'd0);
        tick = 1'b1; move_left = 1'b1;
        for (int i = 0; i < 5; i++) cyc("left");
        check_const("left_wall_c0", gx(0), 0);
        check_const("left_wall_pivot", gx(1), 1);
        move_right = 1'b1;
        for (int i = 0; i < 2; i++) cyc("left_right");
        check_const("lr_none", gx(0), 0);

        // I rotation and rotation blocked by the right wall
        do_reset();
        spawn(3'd0);
        tick = 1'b1; rotate_cw = 1'b1; cyc("rot");
        rotate_cw = 1'b0;
        check_const("rot_c0", gx(0)*100 + gy(0), 419);
        check_const("rot_c3", gx(3)*100 + gy(3), 416);
        check_const("rot_orient", int'(orient), 1);
        move_right = 1'b1;
        for (int i = 0; i < 5; i++) cyc("right");
        move_right = 1'b0;
        check_const("right_x", gx(0), 9);
        rotate_cw = 1'b1; cyc("rot_wall");
        rotate_cw = 1'b0;
        check_const("rot_wall_orient", int'(orient), 1);

        // Soft drop to the floor and the lock handshake
        do_reset();
        spawn(3'd2);
        tick = 1'b1; soft_drop = 1'b1;
        n = 0;
        while (lock_valid !== 1'b1 && n < 100) begin cyc("land"); n++; end
        check_const("land_lock_valid", int'(lock_valid), 1);
        check_const("land_floor", gy(0), 0);
        for (int i = 0; i < 10; i++) cyc("lock_hold");
        check_const("lock_held", int'(lock_valid), 1);
        check_const("lock_cells", gy(3), 1);
        lock_ack = 1'b1; cyc("lock_ack");
        lock_ack = 1'b0;
        check_const("ack_released", int'(lock_valid), 0);

        // Spawn collision leads to a sticky game over
        board[(ROWS-2)*COLS + 4] = 1'b1;
        spawn(3'd2);
        check_const("over_flag", int'(game_over), 1);
        check_const("over_inactive", int'(active), 0);
        tick = 1'b1;
        for (int i = 0; i < 5; i++) cyc("over_hold");
        check_const("over_sticky", int'(game_over), 1);
        board = '0;
        do_reset();
        check_const("rst2_over", int'(game_over), 0);
        check_const("rst2_cells", int'(cell_y), 0);

        // Random play against the model
        for (int i = 0; i < 4000; i++) begin
            reset       = ($urandom_range(0, 199) == 0) || (m_mode == M_OVER && $urandom_range(0, 9) == 0);
            tick        = ($urandom_range(0, 1) == 1);
            spawn_req   = ($urandom_range(0, 3) == 0);
            spawn_shape = 3'($urandom_range(0, 7));
            move_left   = ($urandom_range(0, 9) < 3);
            move_right  = ($urandom_range(0, 9) < 3);
            rotate_cw   = ($urandom_range(0, 9) < 2);
            soft_drop   = ($urandom_range(0, 9) < 6);
            lock_ack    = ($urandom_range(0, 9) < 3);
            if (m_mode == M_IDLE && $urandom_range(0, 3) == 0) new_board();
            cyc("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
